// File: rtl/id_ex_pkg.sv
// Shared decode constants, ALU encodings and the EX control bundle for the
// ID/EX stage of the five-stage MIPS subset pipeline.
package id_ex_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic       valid;
    alu_op_t    op;
    logic       binv;
    logic       use_imm;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } ctrl_t;

  // Unsupported encodings come back all-zero, i.e. as a bubble.
  function automatic ctrl_t decode(input logic [5:0] opcode,
                                   input logic [5:0] funct,
                                   input logic [4:0] rt,
                                   input logic [4:0] rd);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.valid    = 1'b1;
        c.regwrite = 1'b1;
        c.rd       = rd;
        case (funct)
          FN_ADD:  c.op = ALU_ADD;
          FN_SUB: begin
            c.op   = ALU_ADD;
            c.binv = 1'b1;
          end
          FN_AND:  c.op = ALU_AND;
          FN_OR:   c.op = ALU_OR;
          FN_SLT: begin
            c.op   = ALU_SLT;
            c.binv = 1'b1;
          end
          default: c = '0;
        endcase
      end
      OP_ADDI: begin
        c.valid    = 1'b1;
        c.op       = ALU_ADD;
        c.use_imm  = 1'b1;
        c.rd       = rt;
        c.regwrite = 1'b1;
      end
      OP_LW: begin
        c.valid    = 1'b1;
        c.op       = ALU_ADD;
        c.use_imm  = 1'b1;
        c.rd       = rt;
        c.regwrite = 1'b1;
        c.memread  = 1'b1;
      end
      OP_SW: begin
        c.valid    = 1'b1;
        c.op       = ALU_ADD;
        c.use_imm  = 1'b1;
        c.memwrite = 1'b1;
      end
      OP_BEQ: begin
        c.valid = 1'b1;
        c.op    = ALU_ADD;
        c.binv  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // rt is a source operand only for R-type, sw and beq; for addi/lw it is the destination.
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand's bypass selector: EX/MEM result beats MEM/WB data, which beats
// the value latched from the register file. $0 never matches.
module fwd_mux
  import id_ex_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [31:0] latched,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] data
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src);
  assign hit_memwb = memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src);

  always_comb begin
    data = latched;
    if (hit_exmem) begin
      data = exmem_result;
    end else if (hit_memwb) begin
      data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode, load-use hazard detection, operand
// forwarding and a saturating count of load-use stall cycles.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   id_valid,
  input  logic [5:0]             id_opcode,
  input  logic [5:0]             id_funct,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic [31:0]            id_rs_data,
  input  logic [31:0]            id_rt_data,
  input  logic [31:0]            id_imm,
  input  logic                   flush,
  input  logic                   exmem_regwrite,
  input  logic [4:0]             exmem_rd,
  input  logic [31:0]            exmem_result,
  input  logic                   memwb_regwrite,
  input  logic [4:0]             memwb_rd,
  input  logic [31:0]            memwb_data,
  output logic                   stall,
  output logic [31:0]            A,
  output logic [31:0]            B,
  output logic [1:0]             op,
  output logic                   binv,
  output logic                   ex_valid,
  output logic [4:0]             ex_rd,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   ex_memwrite,
  output logic [31:0]            ex_store_data,
  output logic [STALL_CNT_W-1:0] stall_count
);

  ctrl_t       dec;
  ctrl_t       ex_ctrl;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic        rs_hazard;
  logic        rt_hazard;
  logic        load_id;

  always_comb begin
    dec = decode(id_opcode, id_funct, id_rt, id_rd);
  end

  // Back-pressure contract: stall=1 means decode and PC must hold the same
  // instruction next cycle; it is only accepted into EX on a cycle with stall=0.
  assign rs_hazard = (ex_ctrl.rd == id_rs);
  assign rt_hazard = (ex_ctrl.rd == id_rt) && reads_rt(id_opcode);
  assign stall = ex_ctrl.valid && ex_ctrl.memread && (ex_ctrl.rd != 5'd0) &&
                 id_valid && (rs_hazard || rt_hazard);

  // Flush outranks stall, which outranks an empty or unsupported slot.
  assign load_id = !flush && !stall && id_valid && dec.valid;

  always_ff @(posedge CLK) begin
    if (RST || !load_id) begin
      ex_ctrl    <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
    end else begin
      ex_ctrl    <= dec;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
    end
  end

  // A stall coinciding with a flush is not a load-use stall cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count <= '0;
    end else if (stall && !flush && !(&stall_count)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  fwd_mux u_fwd_rs (
    .src            (ex_rs),
    .latched        (ex_rs_data),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .data           (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .src            (ex_rt),
    .latched        (ex_rt_data),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .data           (fwd_rt)
  );

  always_comb begin
    A             = '0;
    B             = '0;
    op            = ALU_AND;
    binv          = 1'b0;
    ex_valid      = 1'b0;
    ex_rd         = '0;
    ex_regwrite   = 1'b0;
    ex_memread    = 1'b0;
    ex_memwrite   = 1'b0;
    ex_store_data = '0;
    if (ex_ctrl.valid) begin
      A             = fwd_rs;
      B             = ex_ctrl.use_imm ? ex_imm : fwd_rt;
      op            = ex_ctrl.op;
      binv          = ex_ctrl.binv;
      ex_valid      = 1'b1;
      ex_rd         = ex_ctrl.rd;
      ex_regwrite   = ex_ctrl.regwrite;
      ex_memread    = ex_ctrl.memread;
      ex_memwrite   = ex_ctrl.memwrite;
      ex_store_data = fwd_rt;
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: STALL_CNT_W, 16, width of the saturating load-use stall counter.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  decode presents an instruction this cycle.
REQ-005 id_opcode, id_funct  in  6 each  MIPS opcode/funct fields.
REQ-006 id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-007 id_rs_data, id_rt_data, id_imm  in  32 each  register-file reads; sign-extended immediate.
REQ-008 flush  in  1  branch-taken squash of the instruction entering EX.
REQ-009 exmem_regwrite, exmem_rd, exmem_result  in  1/5/32  forwarding source: ALU result register.
REQ-010 memwb_regwrite, memwb_rd, memwb_data  in  1/5/32  forwarding source: writeback.
REQ-011 stall  out  1  combinational; decode and PC hold when 1.
REQ-012 A, B  out  32 each  ALU operands.
REQ-013 op  out  2  ALU op (00 AND, 01 OR, 10 ADD, 11 SLT); binv  out  1  invert B, carry-in 1.
REQ-014 ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite  out  1/5/1/1/1  EX control.
REQ-015 ex_store_data  out  32  forwarded rt value for sw.
REQ-016 stall_count  out  STALL_CNT_W  number of load-use stall cycles.

Function
REQ-017 Decode SHALL map: R-type funct 0x20 add->op 10, binv 0; 0x22 sub->10/1; 0x24 and->00/0; 0x25 or->01/0; 0x2A slt->11/1; all with regwrite, dest rd.
REQ-018 Decode SHALL map: addi 0x08->10/0, B=imm, dest rt, regwrite; lw 0x23->10/0, B=imm, dest rt, regwrite, memread; sw 0x2B->10/0, B=imm, memwrite; beq 0x04->10/1, B=rt, no writes.
REQ-019 Unsupported opcode/funct SHALL enter EX as a bubble (ex_valid 0, all enables 0).
REQ-020 Pipeline register SHALL latch rs/rt data, rs/rt specifiers, imm, decoded controls and dest each cycle; latency ID->EX exactly 1 cycle.
REQ-021 Next-cycle EX register SHALL be a bubble when flush=1, else when stall=1, else when id_valid=0; flush has highest priority.
REQ-022 stall SHALL be 1 when ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs | (ex_rd==id_rt & instruction reads rt)) & id_valid; rt read by R-type, sw, beq only.
REQ-023 Forwarding SHALL be combinational in EX on the latched rs and rt values: exmem source if exmem_regwrite & exmem_rd!=0 & rd match; else memwb source under same rule; else latched value. exmem wins over memwb.
REQ-024 A SHALL be forwarded rs; B SHALL be imm for addi/lw/sw, else forwarded rt; ex_store_data SHALL be forwarded rt.
REQ-025 When ex_valid=0, A, B, op, binv, ex_store_data SHALL be 0 and enables 0.
REQ-026 Register $0 SHALL never be a forwarding or stall match.
REQ-027 stall_count SHALL increment each cycle stall=1 and flush=0, saturating at all-ones.
REQ-028 Simultaneous flush and stall: bubble inserted, stall still asserted to decode, counter not incremented.

Reset
REQ-029 RST=1 at a rising edge SHALL clear all pipeline-register fields and stall_count to 0; ex_valid 0, op 00, binv 0.
REQ-030 Reset mid-stall SHALL discard the held instruction; stall deasserts the cycle after reset since ex_valid=0.

Structure
REQ-031 Shared package SHALL hold opcode/funct constants (0x00, 0x08, 0x23, 0x2B, 0x04; 0x20, 0x22, 0x24, 0x25, 0x2A) and ALU op encodings 00/01/10/11.
REQ-032 Forwarding mux SHALL be one sub-module, fwd_mux, instantiated twice (rs, rt).

Verification
REQ-033 add $3,$1,$2 with rs=5, rt=7 -> next cycle ex_valid=1, A=5, B=7, op=10, binv=0, ex_rd=3.
REQ-034 sub then slt with exmem_rd=1, exmem_result=0x10, memwb_rd=1, memwb_data=0x20 -> A=0x10 (exmem priority); slt op=11, binv=1.
REQ-035 lw $4,8($1) followed by add $5,$4,$2 -> stall=1 one cycle, bubble in EX, stall_count=1, add enters EX next cycle.
REQ-036 flush=1 with valid add and pending load-use -> EX bubble, ex_regwrite=0, stall_count unchanged.
REQ-037 sw $2,4($1) with memwb_rd=2, memwb_data=0xDEAD -> B=4, ex_store_data=0xDEAD, ex_memwrite=1.
REQ-038 exmem_rd=0, exmem_regwrite=1, exmem_result=0xFFFF with rs=0 -> A=latched 0, no forward; RST mid-run -> all outputs 0 next cycle.
